// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types and constants for the AXI-Stream packet FIFO.
package axis_pkg;

  // Default beat width used by the shared beat type and the bus interface
  localparam int AXIS_DATA_W = 32;

  // Operating mode selectors for the PKT_MODE parameter
  localparam int AXIS_MODE_STREAM = 0;
  localparam int AXIS_MODE_PKT    = 1;

  // One stored beat: payload, byte enables and end-of-packet marker
  typedef struct packed {
    logic [AXIS_DATA_W-1:0]   tdata;
    logic [AXIS_DATA_W/8-1:0] tkeep;
    logic                     tlast;
  } axis_beat_t;

  // Packet-mode output gate: HOLD waits for a whole packet, FWD cuts through
  typedef enum logic {
    HOLD = 1'b0,
    FWD  = 1'b1
  } axis_pkt_state_e;

endpackage

// File: rtl/axis_pkt_fifo_if.sv
// AXI-Stream link bundle with producer (master) and consumer (slave) views.
interface axis_if
  import axis_pkg::*;
#(
  parameter int DATA_W = AXIS_DATA_W
) ();

  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  // Side that drives the beat
  modport master (
    output tdata,
    output tkeep,
    output tlast,
    output tvalid,
    input  tready
  );

  // Side that accepts the beat
  modport slave (
    input  tdata,
    input  tkeep,
    input  tlast,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/axis_pkt_fifo_ram.sv
// Beat storage: simple dual-port array, synchronous write, asynchronous read.
module axis_fifo_ram
  import axis_pkg::*;
#(
  parameter int  DEPTH  = 16,
  parameter type beat_t = axis_beat_t
) (
  input  logic                     clk,
  input  logic                     wrEn_i,
  input  logic [$clog2(DEPTH)-1:0] wrAddr_i,
  input  beat_t                    wrData_i,
  input  logic [$clog2(DEPTH)-1:0] rdAddr_i,
  output beat_t                    rdData_o
);

  beat_t mem_q [DEPTH];

  // Store the incoming beat; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      mem_q[wrAddr_i] <= wrData_i;
    end
  end

  assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with first-word fall-through, tkeep/tlast sidebands and an
// optional store-and-forward packet mode that falls back to cut-through when
// a single packet cannot fit.
module axis_pkt_fifo
  import axis_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int PKT_MODE = AXIS_MODE_STREAM
) (
  input  logic                   clk,
  input  logic                   rst,
  axis_if.slave                  s,
  axis_if.master                 m,
  output logic [$clog2(DEPTH):0] level,
  output logic                   oversize
);

  localparam int AW = $clog2(DEPTH);
  localparam bit IS_PKT = (PKT_MODE == AXIS_MODE_PKT);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef struct packed {
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tlast;
  } beat_t;

  logic [AW:0]     wrPtr_q, wrPtr_d;
  logic [AW:0]     rdPtr_q, rdPtr_d;
  logic [AW:0]     pktCnt_q, pktCnt_d;
  axis_pkt_state_e state_q, state_d;
  logic            readyEn_q;

  logic  empty;
  logic  full;
  logic  push;
  logic  pop;
  logic  pushLast;
  logic  popLast;
  beat_t wrBeat;
  beat_t headBeat;

  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                 (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

  assign s.tready = readyEn_q && !full;
  assign push     = s.tvalid && s.tready;
  assign pop      = m.tvalid && m.tready;
  assign pushLast = push && s.tlast;
  assign popLast  = pop && headBeat.tlast;

  assign wrBeat = {s.tdata, s.tkeep, s.tlast};

  // Stream mode exposes any stored beat; packet mode waits for a complete
  // packet unless the oversize fallback has switched it to cut-through.
  assign m.tvalid = IS_PKT ? (!empty && ((state_q == FWD) || (pktCnt_q != '0)))
                           : !empty;

  // A full FIFO with no packet end inside can never complete: flag it once
  assign oversize = IS_PKT && (state_q == HOLD) && full && (pktCnt_q == '0);

  assign m.tdata = headBeat.tdata;
  assign m.tkeep = headBeat.tkeep;
  assign m.tlast = headBeat.tlast;

  assign level = wrPtr_q - rdPtr_q;

  axis_fifo_ram #(
    .DEPTH  (DEPTH),
    .beat_t (beat_t)
  ) u_ram (
    .clk      (clk),
    .wrEn_i   (push),
    .wrAddr_i (wrPtr_q[AW-1:0]),
    .wrData_i (wrBeat),
    .rdAddr_i (rdPtr_q[AW-1:0]),
    .rdData_o (headBeat)
  );

  // Pointer advance, stored-packet count and packet-mode gate transitions
  always_comb begin
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    pktCnt_d = pktCnt_q;
    state_d  = state_q;
    if (push) begin
      wrPtr_d = wrPtr_q + PTR_ONE;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PTR_ONE;
    end
    case ({pushLast, popLast})
      2'b10:   pktCnt_d = pktCnt_q + PTR_ONE;
      2'b01:   pktCnt_d = pktCnt_q - PTR_ONE;
      default: pktCnt_d = pktCnt_q;
    endcase
    if (IS_PKT) begin
      case (state_q)
        HOLD: begin
          if (full && (pktCnt_q == '0)) begin
            state_d = FWD;
          end
        end
        FWD: begin
          if (popLast) begin
            state_d = HOLD;
          end
        end
        default: state_d = HOLD;
      endcase
    end
  end

  // Register update; reset empties the FIFO and keeps s_tready low until
  // the first clock edge after release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      pktCnt_q  <= '0;
      state_q   <= HOLD;
      readyEn_q <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      pktCnt_q  <= pktCnt_d;
      state_q   <= state_d;
      readyEn_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Self-checking bench: one stream-mode and one packet-mode FIFO driven side by
// side, compared every cycle against a queue-style reference model.
module tb_axis_pkt_fifo;
  import axis_pkg::*;

  localparam int DW    = 32;
  localparam int KW    = DW / 8;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int HN    = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  axis_if #(.DATA_W(DW)) sIf0 ();
  axis_if #(.DATA_W(DW)) mIf0 ();
  axis_if #(.DATA_W(DW)) sIf1 ();
  axis_if #(.DATA_W(DW)) mIf1 ();

  logic [DW-1:0] sData  [2];
  logic [KW-1:0] sKeep  [2];
  logic          sLast  [2];
  logic          sValid [2];
  logic          mReady [2];

  logic [LW-1:0] level0, level1;
  logic          oversize0, oversize1;

  assign sIf0.tdata  = sData[0];
  assign sIf0.tkeep  = sKeep[0];
  assign sIf0.tlast  = sLast[0];
  assign sIf0.tvalid = sValid[0];
  assign mIf0.tready = mReady[0];
  assign sIf1.tdata  = sData[1];
  assign sIf1.tkeep  = sKeep[1];
  assign sIf1.tlast  = sLast[1];
  assign sIf1.tvalid = sValid[1];
  assign mIf1.tready = mReady[1];

  axis_pkt_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .PKT_MODE(AXIS_MODE_STREAM)) dutStream (
    .clk(clk), .rst(rst), .s(sIf0), .m(mIf0), .level(level0), .oversize(oversize0));

  axis_pkt_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .PKT_MODE(AXIS_MODE_PKT)) dutPkt (
    .clk(clk), .rst(rst), .s(sIf1), .m(mIf1), .level(level1), .oversize(oversize1));

  // Reference model: every beat ever accepted is logged in order; the FIFO
  // contents are the log entries between the read and write counts.
  logic [DW-1:0] histData [2][HN];
  logic [KW-1:0] histKeep [2][HN];
  logic          histLast [2][HN];
  int wrCnt   [2];
  int rdCnt   [2];
  int lastCnt [2];
  bit cut     [2];
  bit readyOn;

  int checks   = 0;
  int failures = 0;
  int overSeen = 0;

  function automatic int modelLevel(input int d);
    return wrCnt[d] - rdCnt[d];
  endfunction

  function automatic bit modelReady(input int d);
    return readyOn && (modelLevel(d) < DEPTH);
  endfunction

  function automatic bit modelValid(input int d);
    if (modelLevel(d) == 0) return 1'b0;
    if (d == 0) return 1'b1;
    return cut[d] || (lastCnt[d] > 0);
  endfunction

  function automatic bit modelOversize(input int d);
    return (d == 1) && !cut[d] && (modelLevel(d) == DEPTH) && (lastCnt[d] == 0);
  endfunction

  function automatic logic [LW-1:0] obsLevel(input int d);
    return (d == 0) ? level0 : level1;
  endfunction

  task automatic checkConst(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input int d);
    logic [DW-1:0] oData;
    logic [KW-1:0] oKeep;
    logic          oLast, oValid, oReady, oOver;
    logic [LW-1:0] oLevel;
    int            sz;
    int            idx;
    bit            eValid;
    oData  = (d == 0) ? mIf0.tdata  : mIf1.tdata;
    oKeep  = (d == 0) ? mIf0.tkeep  : mIf1.tkeep;
    oLast  = (d == 0) ? mIf0.tlast  : mIf1.tlast;
    oValid = (d == 0) ? mIf0.tvalid : mIf1.tvalid;
    oReady = (d == 0) ? sIf0.tready : sIf1.tready;
    oOver  = (d == 0) ? oversize0   : oversize1;
    oLevel = obsLevel(d);
    sz     = modelLevel(d);
    idx    = rdCnt[d] % HN;
    eValid = modelValid(d);
    checks++;
    assert (oLevel === LW'(sz)) else begin
      failures++;
      $error("[TB] FAIL level dut%0d t=%0t observed=%0d expected=%0d", d, $time, oLevel, sz);
    end
    checks++;
    assert (oReady === modelReady(d)) else begin
      failures++;
      $error("[TB] FAIL s_tready dut%0d t=%0t observed=%b expected=%b", d, $time, oReady, modelReady(d));
    end
    checks++;
    assert (oValid === eValid) else begin
      failures++;
      $error("[TB] FAIL m_tvalid dut%0d t=%0t observed=%b expected=%b", d, $time, oValid, eValid);
    end
    checks++;
    assert (oOver === modelOversize(d)) else begin
      failures++;
      $error("[TB] FAIL oversize dut%0d t=%0t observed=%b expected=%b", d, $time, oOver, modelOversize(d));
    end
    if (eValid) begin
      checks++;
      assert ({oData, oKeep, oLast} === {histData[d][idx], histKeep[d][idx], histLast[d][idx]}) else begin
        failures++;
        $error("[TB] FAIL head dut%0d t=%0t observed=%h/%h/%b expected=%h/%h/%b", d, $time,
               oData, oKeep, oLast, histData[d][idx], histKeep[d][idx], histLast[d][idx]);
      end
    end
  endtask

  // One clock: check both DUTs, predict handshakes, advance the model
  task automatic tick();
    bit push [2];
    bit pop  [2];
    bit over [2];
    for (int d = 0; d < 2; d++) begin
      checkOutput(d);
      push[d] = sValid[d] && modelReady(d);
      pop[d]  = modelValid(d) && mReady[d];
      over[d] = modelOversize(d);
    end
    if (oversize1 === 1'b1) overSeen++;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (over[d]) cut[d] = 1'b1;
      if (pop[d]) begin
        if (histLast[d][rdCnt[d] % HN]) begin
          lastCnt[d]--;
          cut[d] = 1'b0;
        end
        rdCnt[d]++;
      end
      if (push[d]) begin
        histData[d][wrCnt[d] % HN] = sData[d];
        histKeep[d][wrCnt[d] % HN] = sKeep[d];
        histLast[d][wrCnt[d] % HN] = sLast[d];
        wrCnt[d]++;
        if (sLast[d]) lastCnt[d]++;
      end
    end
    readyOn = !rst;
  endtask

  task automatic applyStimulus(input int d, input bit v, input logic [DW-1:0] data,
                               input logic [KW-1:0] keep, input bit last, input bit rdy);
    sValid[d] = v;
    sData[d]  = data;
    sKeep[d]  = keep;
    sLast[d]  = last;
    mReady[d] = rdy;
  endtask

  task automatic idleAll();
    for (int d = 0; d < 2; d++) applyStimulus(d, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      rdCnt[d]   = wrCnt[d];
      lastCnt[d] = 0;
      cut[d]     = 1'b0;
    end
    readyOn = 1'b0;
  endtask

  task automatic drain(input int d, input int bound);
    sValid[d] = 1'b0;
    mReady[d] = 1'b1;
    for (int i = 0; i < bound && modelLevel(d) != 0; i++) tick();
    checkConst($sformatf("drain dut%0d", d), 32'(obsLevel(d)), 0);
  endtask

  initial begin
    int n;
    int guard;
    logic [DW-1:0] base;
    for (int d = 0; d < 2; d++) begin
      wrCnt[d] = 0;
      rdCnt[d] = 0;
      lastCnt[d] = 0;
      cut[d] = 1'b0;
    end
    readyOn = 1'b0;
    idleAll();

    // Reset state
    #1 rst = 1'b1;
    #1;
    checkOutput(0);
    checkOutput(1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Fill to full in stream mode, then drain in order
    $display("[TB] fill to full");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 1'b1, DW'(i), KW'($urandom()), 1'($urandom()), 1'b0);
      tick();
    end
    sValid[0] = 1'b0;
    checkConst("full level", 32'(level0), DEPTH);
    checkConst("full s_tready", 32'(sIf0.tready), 0);
    drain(0, 40);

    // Wrap-around with a 3-cycle m_tready pattern
    $display("[TB] wrap-around");
    n = wrCnt[0];
    guard = 0;
    while ((wrCnt[0] - n) < 40 && guard < 400) begin
      applyStimulus(0, ($urandom() % 4) != 0, $urandom(), KW'($urandom()),
                    ($urandom() % 5) == 0, (guard % 3) != 2);
      tick();
      guard++;
    end
    checkConst("wrap pushed", 32'(wrCnt[0] - n), 40);
    drain(0, 60);

    // Packet hold: 5-beat packet appears only after its tlast is stored
    $display("[TB] packet hold");
    idleAll();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1'b1, $urandom(), KW'($urandom()), i == 4, 1'b1);
      tick();
      if (i < 4) checkConst("hold m_tvalid", 32'(mIf1.tvalid), 0);
    end
    checkConst("release m_tvalid", 32'(mIf1.tvalid), 1);
    drain(1, 20);

    // Oversize packet: 20 beats fall back to cut-through once
    $display("[TB] oversize");
    overSeen = 0;
    base = $urandom();
    n = 0;
    guard = 0;
    while (n < 20 && guard < 200) begin
      applyStimulus(1, 1'b1, base + DW'(n), KW'(n), n == 19, 1'b1);
      if (modelReady(1)) n++;
      tick();
      guard++;
    end
    drain(1, 40);
    checkConst("oversize pulses", 32'(overSeen), 1);

    // Simultaneous tlast push and tlast pop at level 8, one stored packet
    $display("[TB] simultaneous");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1'b1, $urandom(), KW'($urandom()), i == 0, 1'b0);
      tick();
    end
    checkConst("pre level", 32'(level1), 8);
    applyStimulus(1, 1'b1, $urandom(), KW'($urandom()), 1'b1, 1'b1);
    tick();
    sValid[1] = 1'b0;
    mReady[1] = 1'b0;
    checkConst("post level", 32'(level1), 8);
    checkConst("post m_tvalid", 32'(mIf1.tvalid), 1);
    tick();
    drain(1, 20);

    // Reset mid-packet discards contents immediately
    $display("[TB] reset mid-packet");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1'b1, $urandom(), KW'($urandom()), 1'b0, 1'b1);
      tick();
    end
    rst = 1'b1;
    #1;
    checkConst("rst level", 32'(level1), 0);
    checkConst("rst m_tvalid", 32'(mIf1.tvalid), 0);
    checkConst("rst s_tready", 32'(sIf1.tready), 0);
    modelReset();
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1'b1, $urandom(), KW'($urandom()), i == 3, 1'b1);
      guard = 0;
      while (!modelReady(1) && guard < 5) begin
        tick();
        guard++;
      end
      tick();
    end
    drain(1, 20);

    // Random traffic on both modes together
    $display("[TB] random");
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        applyStimulus(d, ($urandom() % 4) != 0, $urandom(), KW'($urandom()),
                      ($urandom() % 10) == 0, ($urandom() % 3) != 0);
      end
      tick();
    end
    idleAll();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
